// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : grf_wb_arbiter                                               |
// | Description : Write-side front end of the general register file. Merges    |
// |               the in-order W-stage writeback (primary) with results from   |
// |               variable-latency producers (secondary) onto the register     |
// |               file's single write port. Primary writes always win;         |
// |               secondary writes wait in a small FIFO and drain in cycles    |
// |               where the write port is otherwise idle.                      |
// | Ports       : clk, reset (sync, active-high)                               |
// |               iP_WE/iP_Addr/iP_Data/iP_PC8     primary write request       |
// |               iS_Valid/iS_Addr/iS_Data/iS_PC8  secondary offer             |
// |               oS_Ready                         secondary accepted          |
// |               oWE/oA3_Addr/oWD/oPC8            register file write port    |
// |               oPending                         regs with a live queued     |
// |                                                write (bit 0 always 0)      |
// | Options     : WB_TRACE_EN - print every committed write to the log         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module grf_wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iP_WE,
    input  logic [4:0]  iP_Addr,
    input  logic [31:0] iP_Data,
    input  logic [31:0] iP_PC8,
    input  logic        iS_Valid,
    input  logic [4:0]  iS_Addr,
    input  logic [31:0] iS_Data,
    input  logic [31:0] iS_PC8,
    output logic        oS_Ready,
    output logic        oWE,
    output logic [4:0]  oA3_Addr,
    output logic [31:0] oWD,
    output logic [31:0] oPC8,
    output logic [31:0] oPending
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    // An entry's live bit is cleared when it is popped, so live=1 also
    // implies the slot is occupied.
    logic [DEPTH-1:0] r_live;
    logic [4:0]       r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [31:0]      r_pc8  [DEPTH];

    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;
    logic             w_p_live;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [31:0]      w_pend;

    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];
    assign w_p_live = iP_WE && (iP_Addr != 5'd0);
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign oS_Ready = !w_full;
    assign w_push   = iS_Valid && !w_full;
    // The head is never presented while reset is held, so a reset landing
    // mid-drain cannot leak a partial write.
    assign w_pop    = !w_p_live && !w_empty && !reset;

    // Write port mux: primary has absolute priority, then the FIFO head.
    always_comb begin
        oWE      = 1'b0;
        oA3_Addr = 5'd0;
        oWD      = 32'd0;
        oPC8     = 32'd0;
        if (w_p_live) begin
            oWE      = 1'b1;
            oA3_Addr = iP_Addr;
            oWD      = iP_Data;
            oPC8     = iP_PC8;
        end else if (w_pop) begin
            oWE      = r_live[w_rd_idx];
            oA3_Addr = r_addr[w_rd_idx];
            oWD      = r_data[w_rd_idx];
            oPC8     = r_pc8[w_rd_idx];
        end
    end

    // Control state: pointers and live bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_live   <= '0;
        end else begin
            // A live primary write to X makes every older queued write to X
            // stale. The push below overrides this for its own slot, so a
            // same-cycle push to X survives.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_p_live && (r_addr[i] == iP_Addr)) begin
                    r_live[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_live[w_rd_idx] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_live[w_wr_idx] <= (iS_Addr != 5'd0);
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[w_wr_idx] <= iS_Addr;
            r_data[w_wr_idx] <= iS_Data;
            r_pc8[w_wr_idx]  <= iS_PC8;
        end
    end

    // Pending vector for the hazard unit, derived from registered state.
    always_comb begin
        w_pend = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_live[i] && (r_addr[i] != 5'd0)) begin
                w_pend[r_addr[i]] = 1'b1;
            end
        end
    end

    assign oPending = w_pend;

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && oWE) begin
            $display("%d@%h: $%d <= %h", $time, oPC8 - 32'd8, oA3_Addr, oWD);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_grf_wb_arbiter                                            |
// | Description : Self-checking bench for grf_wb_arbiter (DEPTH=4). A table of |
// |               directed cycles with hand-derived expectations, followed by  |
// |               randomized traffic checked against a queue-based model.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_grf_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        iP_WE;
    logic [4:0]  iP_Addr;
    logic [31:0] iP_Data;
    logic [31:0] iP_PC8;
    logic        iS_Valid;
    logic [4:0]  iS_Addr;
    logic [31:0] iS_Data;
    logic [31:0] iS_PC8;
    logic        oS_Ready;
    logic        oWE;
    logic [4:0]  oA3_Addr;
    logic [31:0] oWD;
    logic [31:0] oPC8;
    logic [31:0] oPending;

    grf_wb_arbiter #(.DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .iP_WE    (iP_WE),
        .iP_Addr  (iP_Addr),
        .iP_Data  (iP_Data),
        .iP_PC8   (iP_PC8),
        .iS_Valid (iS_Valid),
        .iS_Addr  (iS_Addr),
        .iS_Data  (iS_Data),
        .iS_PC8   (iS_PC8),
        .oS_Ready (oS_Ready),
        .oWE      (oWE),
        .oA3_Addr (oA3_Addr),
        .oWD      (oWD),
        .oPC8     (oPC8),
        .oPending (oPending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vectors: one row = inputs held for one cycle plus the
    // outputs expected during that cycle (before the closing edge).
    // ------------------------------------------------------------------
    typedef struct {
        bit        rst;
        bit        chk;
        bit        pwe;
        bit [4:0]  pa;
        bit [31:0] pd;
        bit [31:0] pp;
        bit        sv;
        bit [4:0]  sa;
        bit [31:0] sd;
        bit [31:0] sp;
        bit        we;
        bit [4:0]  a;
        bit [31:0] wd;
        bit [31:0] pc;
        bit        rdy;
        bit [31:0] pend;
    } vec_t;

    function automatic vec_t mk(bit rst, bit chk, bit pwe, bit [4:0] pa, bit [31:0] pd,
                                bit [31:0] pp, bit sv, bit [4:0] sa, bit [31:0] sd,
                                bit [31:0] sp, bit we, bit [4:0] a, bit [31:0] wd,
                                bit [31:0] pc, bit rdy, bit [31:0] pend);
        vec_t v;
        v.rst = rst; v.chk = chk; v.pwe = pwe; v.pa = pa; v.pd = pd; v.pp = pp;
        v.sv = sv; v.sa = sa; v.sd = sd; v.sp = sp; v.we = we; v.a = a; v.wd = wd;
        v.pc = pc; v.rdy = rdy; v.pend = pend;
        return v;
    endfunction

    vec_t vt[$];

    // ------------------------------------------------------------------
    // Reference model: the queue holds outstanding secondary writes.
    // ------------------------------------------------------------------
    typedef struct {
        bit        live;
        bit [4:0]  addr;
        bit [31:0] data;
        bit [31:0] pc8;
    } ment_t;

    ment_t q[$];

    task automatic drive(input bit rst, input bit pwe, input bit [4:0] pa, input bit [31:0] pd,
                         input bit [31:0] pp, input bit sv, input bit [4:0] sa,
                         input bit [31:0] sd, input bit [31:0] sp);
        reset = rst; iP_WE = pwe; iP_Addr = pa; iP_Data = pd; iP_PC8 = pp;
        iS_Valid = sv; iS_Addr = sa; iS_Data = sd; iS_PC8 = sp;
    endtask

    initial begin
        bit        pwe, sv, rst;
        bit [4:0]  pa, sa;
        bit [31:0] pd, pp, sd, sp;
        bit        e_we, e_rdy, plive;
        bit [4:0]  e_a;
        bit [31:0] e_wd, e_pc, e_pend;
        ment_t     ne;
        int        sz;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // rst chk pwe pa  pd  pp  sv sa sd sp | we a wd pc rdy pend
        vt.push_back(mk(1,0, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        // primary only
        vt.push_back(mk(0,1, 1,5,32'h1234,32'h3008, 0,0,0,0,        1,5,32'h1234,32'h3008,1,0));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        // secondary in an idle cycle
        vt.push_back(mk(0,1, 0,0,0,0,             1,7,32'hAA,32'h100, 0,0,0,0,1,0));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          1,7,32'hAA,32'h100,1,32'h80));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        // fill under primary load: 5 offers, 4 fit
        vt.push_back(mk(0,1, 1,1,32'h10,32'h200,  1,10,32'hB0,32'h400, 1,1,32'h10,32'h200,1,32'h0));
        vt.push_back(mk(0,1, 1,1,32'h11,32'h204,  1,11,32'hB1,32'h404, 1,1,32'h11,32'h204,1,32'h400));
        vt.push_back(mk(0,1, 1,1,32'h12,32'h208,  1,12,32'hB2,32'h408, 1,1,32'h12,32'h208,1,32'hC00));
        vt.push_back(mk(0,1, 1,1,32'h13,32'h20C,  1,13,32'hB3,32'h40C, 1,1,32'h13,32'h20C,1,32'h1C00));
        vt.push_back(mk(0,1, 1,1,32'h14,32'h210,  1,14,32'hB4,32'h410, 1,1,32'h14,32'h210,0,32'h3C00));
        // primary idles: drain in order, no push while full even with pop
        vt.push_back(mk(0,1, 0,0,0,0,             1,14,32'hB4,32'h410, 1,10,32'hB0,32'h400,0,32'h3C00));
        vt.push_back(mk(0,1, 0,0,0,0,             1,14,32'hB4,32'h410, 1,11,32'hB1,32'h404,1,32'h3800));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          1,12,32'hB2,32'h408,1,32'h7000));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          1,13,32'hB3,32'h40C,1,32'h6000));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          1,14,32'hB4,32'h410,1,32'h4000));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        // kill: queued write to $9 superseded by primary write to $9
        vt.push_back(mk(0,1, 0,0,0,0,             1,9,32'h11,32'h500, 0,0,0,0,1,0));
        vt.push_back(mk(0,1, 1,9,32'h22,32'h600,  0,0,0,0,          1,9,32'h22,32'h600,1,32'h200));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,9,32'h11,32'h500,1,0));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        // same-cycle push to the killed register survives
        vt.push_back(mk(0,1, 0,0,0,0,             1,3,32'h31,32'h700, 0,0,0,0,1,0));
        vt.push_back(mk(0,1, 1,3,32'h32,32'h704,  1,3,32'h33,32'h708, 1,3,32'h32,32'h704,1,32'h8));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,3,32'h31,32'h700,1,32'h8));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          1,3,32'h33,32'h708,1,32'h8));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        // $0 write: accepted, drained, never written
        vt.push_back(mk(0,1, 0,0,0,0,             1,0,32'h44,32'h800, 0,0,0,0,1,0));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,32'h44,32'h800,1,0));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        // reset with three entries queued
        vt.push_back(mk(0,1, 1,2,32'h50,32'h900,  1,20,32'h60,32'hA00, 1,2,32'h50,32'h900,1,0));
        vt.push_back(mk(0,1, 1,2,32'h51,32'h904,  1,21,32'h61,32'hA04, 1,2,32'h51,32'h904,1,32'h100000));
        vt.push_back(mk(0,1, 1,2,32'h52,32'h908,  1,22,32'h62,32'hA08, 1,2,32'h52,32'h908,1,32'h300000));
        vt.push_back(mk(1,0, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));
        vt.push_back(mk(0,1, 0,0,0,0,             0,0,0,0,          0,0,0,0,1,0));

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vt[i].rst, vt[i].pwe, vt[i].pa, vt[i].pd, vt[i].pp,
                  vt[i].sv, vt[i].sa, vt[i].sd, vt[i].sp);
            @(negedge clk);
            if (vt[i].chk) begin
                check($sformatf("row%0d_we", i),   {31'd0, oWE},      {31'd0, vt[i].we});
                check($sformatf("row%0d_addr", i), {27'd0, oA3_Addr}, {27'd0, vt[i].a});
                check($sformatf("row%0d_wd", i),   oWD,               vt[i].wd);
                check($sformatf("row%0d_pc8", i),  oPC8,              vt[i].pc);
                check($sformatf("row%0d_ready", i),{31'd0, oS_Ready}, {31'd0, vt[i].rdy});
                check($sformatf("row%0d_pend", i), oPending,          vt[i].pend);
            end
        end

        // ------------------------------------------------------------------
        // Randomized traffic against the queue model. The secondary producer
        // holds its offer until the model says it was accepted.
        // ------------------------------------------------------------------
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        q.delete();
        sv = 0; sa = 0; sd = 0; sp = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst = (c == 0) || ($urandom_range(0, 99) == 0);
            pwe = ($urandom_range(0, 99) < 55);
            pa  = 5'($urandom_range(0, 7));
            pd  = $urandom;
            pp  = $urandom;
            if (!sv && ($urandom_range(0, 99) < 60)) begin
                sv = 1;
                sa = 5'($urandom_range(0, 7));
                sd = $urandom;
                sp = $urandom;
            end
            drive(rst, pwe, pa, pd, pp, sv, sa, sd, sp);

            // Expected outputs for this cycle from the model state.
            sz     = q.size();
            plive  = pwe && (pa != 0);
            e_rdy  = (sz < DEPTH);
            e_pend = 32'd0;
            foreach (q[k]) if (q[k].live && q[k].addr != 0) e_pend[q[k].addr] = 1'b1;
            e_we = 0; e_a = 0; e_wd = 0; e_pc = 0;
            if (plive) begin
                e_we = 1; e_a = pa; e_wd = pd; e_pc = pp;
            end else if (sz > 0) begin
                e_we = q[0].live; e_a = q[0].addr; e_wd = q[0].data; e_pc = q[0].pc8;
            end

            @(negedge clk);
            if (!rst) begin
                check($sformatf("rnd%0d_we", c),   {31'd0, oWE},      {31'd0, e_we});
                check($sformatf("rnd%0d_addr", c), {27'd0, oA3_Addr}, {27'd0, e_a});
                check($sformatf("rnd%0d_wd", c),   oWD,               e_wd);
                check($sformatf("rnd%0d_pc8", c),  oPC8,              e_pc);
                check($sformatf("rnd%0d_ready", c),{31'd0, oS_Ready}, {31'd0, e_rdy});
                check($sformatf("rnd%0d_pend", c), oPending,          e_pend);
            end

            // Advance the model to the state after the coming edge.
            if (rst) begin
                q.delete();
            end else begin
                if (plive) begin
                    foreach (q[k]) if (q[k].addr == pa) q[k].live = 0;
                end else if (sz > 0) begin
                    void'(q.pop_front());
                end
                if (sv && sz < DEPTH) begin
                    ne.live = (sa != 0); ne.addr = sa; ne.data = sd; ne.pc8 = sp;
                    q.push_back(ne);
                    sv = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-side front end of the general register file: merges the in-order W-stage writeback with results from variable-latency producers (multi-cycle units, delayed load returns) onto the register file's single write port. Primary writes always win; secondary writes are buffered in a small FIFO and drained in idle write-port cycles. A per-register pending vector feeds the hazard unit, so decode stalls on any register that still has a queued write.

## Interface
- DEPTH, 4, secondary FIFO entries; power of two, 2..16
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- iP_WE  in  1  primary (W-stage) write request
- iP_Addr  in  5  primary destination register
- iP_Data  in  32  primary write data
- iP_PC8  in  32  primary instruction PC+8
- iS_Valid  in  1  secondary write offered
- iS_Addr  in  5  secondary destination register
- iS_Data  in  32  secondary write data
- iS_PC8  in  32  secondary instruction PC+8
- oS_Ready  out  1  secondary accepted this cycle when iS_Valid & oS_Ready
- oWE  out  1  register file write enable
- oA3_Addr  out  5  register file write address
- oWD  out  32  register file write data
- oPC8  out  32  PC+8 of the instruction being written back
- oPending  out  32  bit n set while a live queued write targets register n; bit 0 always 0

## Operation
- Primary write is live when iP_WE=1 and iP_Addr!=0; otherwise the port is free for the FIFO.
- Output mux (combinational): primary live -> oWE=1 and oA3_Addr/oWD/oPC8 taken from the primary inputs. Else, if the FIFO is non-empty -> pop the head; oWE = head.live, fields taken from the head. Else oWE=0, all other outputs 0.
- FIFO entry: {live, addr, data, pc8}. Push on iS_Valid & oS_Ready; live = (iS_Addr != 0). A $0 write is accepted and drained but never asserts oWE.
- Ordering kill: on a cycle with a live primary write to register X, every queued entry with addr==X gets live cleared. Decode stalls on oPending, so the primary producer is always younger than any queued write to the same register; the stale value is dropped. A push in the same cycle to the same X is not killed (the secondary write is the younger one).
- oPending[n] = OR over occupied entries of (live & addr==n); updates the cycle after a push, pop or kill.
- oS_Ready = !full. A push and a pop in the same cycle leave the count unchanged. When full, no push happens even if a pop occurs that cycle.
- Pointers are AW=log2(DEPTH) bits with an extra wrap bit; full = pointer MSBs differ and lower bits equal; empty = pointers equal.

## Timing
- Primary path: zero latency, purely combinational to oWE/oA3_Addr/oWD/oPC8.
- Secondary path: push in cycle N -> earliest oWE in cycle N+1. No combinational path from iS_* to oWE.
- Worst-case drain wait is unbounded while the primary stays busy. The producer must hold iS_Valid and its data stable until accepted.
- Reset: pointers and count clear, all entry live bits clear. The cycle after reset: oS_Ready=1, oPending=0, oWE=0 unless a primary write is live. Reset asserted mid-drain discards all queued entries; no partial write.

## Configuration
- WB_TRACE_EN defined: on every posedge with oWE=1 and not reset, print the simulation time, the PC (oPC8 - 8), the register and the data in the format "%d@%h: $%d <= %h". Killed and $0 entries print nothing.
- Not defined: no $display; behaviour is otherwise identical.

## Test plan
- Primary only: iP_WE=1, Addr=5, Data=0x1234, PC8=0x3008 -> same cycle oWE=1, oA3_Addr=5, oWD=0x1234, oPC8=0x3008. FIFO remains empty.
- Secondary in an idle cycle: push Addr=7, Data=0xAA in cycle N -> oPending[7]=1 in cycle N+1, oWE=1/oA3_Addr=7/oWD=0xAA in cycle N+1, oPending=0 in cycle N+2.
- Fill under primary load: primary live every cycle, push 5 entries (DEPTH=4) -> oS_Ready=0 after the 4th push; primary idles -> entries drain in FIFO order, one per cycle, and oS_Ready returns to 1.
- Kill: queue Addr=9 Data=0x11, then primary writes 9 with 0x22 -> next cycle oPending[9]=0; the drained entry gives oWE=0; the register holds 0x22.
- $0 and reset: push Addr=0 -> oPending stays 0 and the drain cycle gives oWE=0. With 3 entries queued, assert reset for 1 cycle -> next cycle oPending=0, oS_Ready=1, no further oWE.
